// File: rtl/apb4_bus_arbiter_if.sv
// rtl/apb4_bus_arbiter_if.sv - requester-side and APB4 completer-side signals of apb4_bus_arbiter
interface apb4_bus_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   localparam int STRB_W = DATA_W / 8;

   // Requester side; requester 1 occupies the upper slice of each packed vector
   logic [1:0]          m_req;
   logic [2*ADDR_W-1:0] m_addr;
   logic [1:0]          m_write;
   logic [2*DATA_W-1:0] m_wdata;
   logic [2*STRB_W-1:0] m_strb;
   logic [1:0]          m_done;
   logic [DATA_W-1:0]   m_rdata;
   logic                m_err;

   // APB4 completer side
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [ADDR_W-1:0]   paddr;
   logic [DATA_W-1:0]   pwdata;
   logic [STRB_W-1:0]   pstrb;
   logic                pready;
   logic                pslverr;
   logic [DATA_W-1:0]   prdata;

   modport master (
      input  m_req, m_addr, m_write, m_wdata, m_strb,
      output m_done, m_rdata, m_err,
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  pready, pslverr, prdata
   );

   modport slave (
      output m_req, m_addr, m_write, m_wdata, m_strb,
      input  m_done, m_rdata, m_err,
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/apb4_bus_arbiter.sv
// rtl/apb4_bus_arbiter.sv - two-requester APB4 arbiter/sequencer with wait-state watchdog
// Define APB4_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to requester 0.
module apb4_bus_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input logic                pclk,
   input logic                presetn,
   apb4_bus_arbiter_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit WDOG_EN = (TIMEOUT > 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state_q, state_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic [1:0]          done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                grant_q, grant_d;
`ifdef APB4_ARB_ROUND_ROBIN_EN
   logic                last_q, last_d;
`endif
   logic [1:0]          eligible;
   logic                win;
   logic                win_write;

   always_ff @(posedge pclk or posedge presetn) begin
      if (presetn) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         grant_q   <= 1'b0;
`ifdef APB4_ARB_ROUND_ROBIN_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
`ifdef APB4_ARB_ROUND_ROBIN_EN
         last_q    <= last_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      done_d    = '0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      // A requester whose done is showing still holds m_req this cycle; mask it out
      eligible  = bus.m_req & ~done_q;
`ifdef APB4_ARB_ROUND_ROBIN_EN
      last_d    = last_q;
      win       = (&eligible) ? ~last_q : eligible[1];
`else
      win       = ~eligible[0];
`endif
      win_write = win ? bus.m_write[1] : bus.m_write[0];

      case (state_q)
         IDLE: begin
            if (|eligible) begin
               grant_d   = win;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = win_write;
               paddr_d   = win ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
               pwdata_d  = !win_write ? '0 :
                           (win ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0]);
               pstrb_d   = !win_write ? '0 :
                           (win ? bus.m_strb[2*STRB_W-1:STRB_W] : bus.m_strb[STRB_W-1:0]);
               state_d   = SETUP;
`ifdef APB4_ARB_ROUND_ROBIN_EN
               last_d    = win;
`endif
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.pready) begin
               rdata_d          = bus.prdata;
               err_d            = bus.pslverr;
               done_d[grant_q]  = 1'b1;
               psel_d           = 1'b0;
               penable_d        = 1'b0;
               state_d          = IDLE;
            end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
               rdata_d          = '0;
               err_d            = 1'b1;
               done_d[grant_q]  = 1'b1;
               psel_d           = 1'b0;
               penable_d        = 1'b0;
               state_d          = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   assign bus.psel    = psel_q;
   assign bus.penable = penable_q;
   assign bus.pwrite  = pwrite_q;
   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
   assign bus.pstrb   = pstrb_q;
   assign bus.m_done  = done_q;
   assign bus.m_rdata = rdata_q;
   assign bus.m_err   = err_q;
endmodule

// File: tb/tb_apb4_bus_arbiter.sv
// tb/tb_apb4_bus_arbiter.sv - scoreboard bench for apb4_bus_arbiter
`timescale 1ns/1ps
module tb_apb4_bus_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int SW = DW / 8;

   typedef struct {
      int          who;
      logic        err;
      logic [15:0] rdata;
      int          cyc;
   } done_t;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
      logic [1:0]  strb;
   } apb_t;

   logic pclk = 1'b0;
   logic presetn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cfg_wait = 0;
   logic [15:0] cfg_rdata = '0;
   logic cfg_err = 1'b0;
   int   wcnt = 0;
   bit   acc_seen = 1'b0;
   done_t done_q[$];
   apb_t  apb_q[$];

   apb4_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   apb4_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_done(input int who, input logic err, input logic [15:0] rd, input int c);
      done_t e;
      e.who = who; e.err = err; e.rdata = rd; e.cyc = c;
      done_q.push_back(e);
   endtask

   task automatic exp_apb(input logic [15:0] a, input logic wr, input logic [15:0] wd, input logic [1:0] st);
      apb_t e;
      e.addr = a; e.wr = wr; e.wdata = wd; e.strb = st;
      apb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #2;
   endtask

   // Requester model: hold m_req until its own done, then release
   task automatic drive(input int who, input logic [15:0] a, input logic wr,
                        input logic [15:0] wd, input logic [1:0] st);
      int n;
      bus.m_addr[who*AW +: AW]  = a;
      bus.m_write[who]          = wr;
      bus.m_wdata[who*DW +: DW] = wd;
      bus.m_strb[who*SW +: SW]  = st;
      bus.m_req[who]            = 1'b1;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!bus.m_done[who] && n < 200);
      if (!bus.m_done[who]) chk($sformatf("done_wait_rq%0d", who), 32'd0, 32'd1);
      @(posedge pclk);
      #2;
      bus.m_req[who] = 1'b0;
   endtask

   // Completer: pready after cfg_wait ACCESS wait states
   always @(negedge pclk) begin
      if (bus.psel && bus.penable) begin
         if (wcnt == cfg_wait) begin
            bus.pready  = 1'b1;
            bus.prdata  = cfg_rdata;
            bus.pslverr = cfg_err;
         end else begin
            bus.pready  = 1'b0;
            bus.prdata  = '0;
            bus.pslverr = 1'b0;
         end
         wcnt++;
      end else begin
         bus.pready  = 1'b0;
         bus.prdata  = '0;
         bus.pslverr = 1'b0;
         wcnt = 0;
      end
   end

   always @(negedge pclk) begin
      apb_t e;
      if (bus.psel && bus.penable && !acc_seen) begin
         acc_seen = 1'b1;
         if (apb_q.size() == 0) begin
            chk("unexpected_access", {16'h0, bus.paddr}, 32'hFFFF_FFFF);
         end else begin
            e = apb_q.pop_front();
            chk("paddr",  {16'h0, bus.paddr},  {16'h0, e.addr});
            chk("pwrite", {31'h0, bus.pwrite}, {31'h0, e.wr});
            chk("pwdata", {16'h0, bus.pwdata}, {16'h0, e.wdata});
            chk("pstrb",  {30'h0, bus.pstrb},  {30'h0, e.strb});
         end
      end else if (!bus.penable) begin
         acc_seen = 1'b0;
      end
   end

   always @(negedge pclk) begin
      done_t e;
      logic [1:0] ev;
      if (bus.m_done != 2'b00) begin
         chk("done_onehot", {31'h0, (bus.m_done == 2'b11)}, 32'd0);
         if (done_q.size() == 0) begin
            chk("unexpected_done", {30'h0, bus.m_done}, 32'd0);
         end else begin
            e  = done_q.pop_front();
            ev = (e.who == 1) ? 2'b10 : 2'b01;
            chk("done_who",   {30'h0, bus.m_done},  {30'h0, ev});
            chk("done_err",   {31'h0, bus.m_err},   {31'h0, e.err});
            chk("done_rdata", {16'h0, bus.m_rdata}, {16'h0, e.rdata});
            if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int t0;
      int first;
      int second;
      presetn     = 1'b1;
      bus.m_req   = '0;
      bus.m_addr  = '0;
      bus.m_write = '0;
      bus.m_wdata = '0;
      bus.m_strb  = '0;
      idle(3);

      chk("rst_psel",    {31'h0, bus.psel},    32'd0);
      chk("rst_penable", {31'h0, bus.penable}, 32'd0);
      chk("rst_pwrite",  {31'h0, bus.pwrite},  32'd0);
      chk("rst_paddr",   {16'h0, bus.paddr},   32'd0);
      chk("rst_pwdata",  {16'h0, bus.pwdata},  32'd0);
      chk("rst_pstrb",   {30'h0, bus.pstrb},   32'd0);
      chk("rst_m_done",  {30'h0, bus.m_done},  32'd0);
      chk("rst_m_rdata", {16'h0, bus.m_rdata}, 32'd0);
      chk("rst_m_err",   {31'h0, bus.m_err},   32'd0);
      presetn = 1'b0;
      idle(2);

      // Single zero-wait write from requester 0
      cfg_wait = 0; cfg_rdata = 16'h0000; cfg_err = 1'b0;
      t0 = cyc;
      exp_apb(16'h1234, 1'b1, 16'hBEEF, 2'b11);
      exp_done(0, 1'b0, 16'h0000, t0 + 3);
      drive(0, 16'h1234, 1'b1, 16'hBEEF, 2'b11);
      idle(2);

      // Read with 3 wait states: write data and strobes must be suppressed
      cfg_wait = 3; cfg_rdata = 16'h5A5A;
      t0 = cyc;
      exp_apb(16'h0040, 1'b0, 16'h0000, 2'b00);
      exp_done(1, 1'b0, 16'h5A5A, t0 + 6);
      drive(1, 16'h0040, 1'b0, 16'h1111, 2'b11);
      idle(2);

      // Completer error with one wait state
      cfg_wait = 1; cfg_rdata = 16'h00FF; cfg_err = 1'b1;
      t0 = cyc;
      exp_apb(16'h0008, 1'b1, 16'h0F0F, 2'b01);
      exp_done(0, 1'b1, 16'h00FF, t0 + 4);
      drive(0, 16'h0008, 1'b1, 16'h0F0F, 2'b01);
      idle(2);

      // Simultaneous reads; last grant was requester 0
      cfg_wait = 0; cfg_rdata = 16'h00C3; cfg_err = 1'b0;
`ifdef APB4_ARB_ROUND_ROBIN_EN
      first = 1;
`else
      first = 0;
`endif
      second = 1 - first;
      t0 = cyc;
      exp_apb((first == 0) ? 16'h0100 : 16'h0200, 1'b0, 16'h0000, 2'b00);
      exp_apb((second == 0) ? 16'h0100 : 16'h0200, 1'b0, 16'h0000, 2'b00);
      exp_done(first, 1'b0, 16'h00C3, t0 + 3);
      exp_done(second, 1'b0, 16'h00C3, t0 + 6);
      fork
         drive(0, 16'h0100, 1'b0, 16'h2222, 2'b11);
         drive(1, 16'h0200, 1'b0, 16'h3333, 2'b01);
      join
      idle(2);

      // Requester 1 withdraws while requester 0 is in ACCESS: it must never be granted
      cfg_wait = 4; cfg_rdata = 16'h1357;
      t0 = cyc;
      exp_apb(16'h0300, 1'b0, 16'h0000, 2'b00);
      exp_done(0, 1'b0, 16'h1357, t0 + 7);
      fork
         drive(0, 16'h0300, 1'b0, 16'h0000, 2'b11);
         begin
            idle(2);
            bus.m_addr[AW +: AW] = 16'h0DDD;
            bus.m_write[1]       = 1'b1;
            bus.m_req[1]         = 1'b1;
            idle(1);
            bus.m_req[1]         = 1'b0;
         end
      join
      idle(4);

      // Watchdog abort: completer never ready
      cfg_wait = 1000; cfg_rdata = 16'hFFFF;
      t0 = cyc;
      exp_apb(16'h0404, 1'b0, 16'h0000, 2'b00);
      exp_done(1, 1'b1, 16'h0000, t0 + 18);
      drive(1, 16'h0404, 1'b0, 16'h0000, 2'b11);
      idle(1);

      // Normal transfer after the abort
      cfg_wait = 0; cfg_rdata = 16'h7777;
      t0 = cyc;
      exp_apb(16'h0006, 1'b1, 16'hA5A5, 2'b10);
      exp_done(0, 1'b0, 16'h7777, t0 + 3);
      drive(0, 16'h0006, 1'b1, 16'hA5A5, 2'b10);
      idle(3);

      // Asynchronous reset during ACCESS: no done, outputs cleared at once
      cfg_wait = 1000;
      exp_apb(16'h0ABC, 1'b1, 16'h4242, 2'b11);
      bus.m_addr[AW +: AW]  = 16'h0ABC;
      bus.m_write[1]        = 1'b1;
      bus.m_wdata[DW +: DW] = 16'h4242;
      bus.m_strb[SW +: SW]  = 2'b11;
      bus.m_req[1]          = 1'b1;
      idle(4);
      chk("hold_m_rdata", {16'h0, bus.m_rdata}, 32'h7777);
      chk("pre_rst_psel", {31'h0, bus.psel}, 32'd1);
      #1;
      presetn = 1'b1;
      #1;
      chk("arst_psel",    {31'h0, bus.psel},    32'd0);
      chk("arst_penable", {31'h0, bus.penable}, 32'd0);
      chk("arst_pwrite",  {31'h0, bus.pwrite},  32'd0);
      chk("arst_paddr",   {16'h0, bus.paddr},   32'd0);
      chk("arst_pwdata",  {16'h0, bus.pwdata},  32'd0);
      chk("arst_pstrb",   {30'h0, bus.pstrb},   32'd0);
      chk("arst_m_done",  {30'h0, bus.m_done},  32'd0);
      chk("arst_m_rdata", {16'h0, bus.m_rdata}, 32'd0);
      chk("arst_m_err",   {31'h0, bus.m_err},   32'd0);
      idle(1);
      bus.m_req[1] = 1'b0;
      idle(1);
      presetn = 1'b0;
      idle(10);

      chk("done_left", done_q.size(), 32'd0);
      chk("apb_left",  apb_q.size(),  32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/apb4_bus_arbiter.md
# apb4_bus_arbiter

Two-requester APB4 master-side arbiter and sequencer. It accepts single-transfer requests from two local masters, selects one, and drives the APB4 SETUP/ACCESS protocol toward a single shared completer. It returns read data, error status and a completion pulse to the winning requester. It sits between the on-chip bus masters and APB completers such as the application peripheral, and adds a wait-state watchdog so a stuck completer cannot hang the bus.

## Interface
Parameters:
- ADDR_W, 16, APB address width
- DATA_W, 16, APB data width (multiple of 8)
- TIMEOUT, 16, maximum ACCESS cycles before forced abort; 0 disables the watchdog

Ports (index i = requester 0/1; packed vectors are requester 1 in the upper slice):
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  reset, asynchronous, active-high (as decided: reset presetn, asynchronous, active-high; clock pclk)
- m_req  in  2  request; held high until the matching m_done
- m_addr  in  2*ADDR_W  request address
- m_write  in  2  1 = write, 0 = read
- m_wdata  in  2*DATA_W  write data
- m_strb  in  2*(DATA_W/8)  write byte strobes
- m_done  out  2  one-cycle completion pulse
- m_rdata  out  DATA_W  read data, valid with m_done
- m_err  out  1  error, valid with m_done (pslverr or timeout)
- psel, penable, pwrite  out  1  APB4 control
- paddr  out  ADDR_W  APB4 address
- pwdata  out  DATA_W  APB4 write data
- pstrb  out  DATA_W/8  APB4 strobes
- pready, pslverr  in  1  APB4 completer response
- prdata  in  DATA_W  APB4 read data

## Operation
- Reset values: all outputs 0; FSM in IDLE; watchdog counter 0; last-grant pointer 1.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible = m_req & ~m_done. If eligible is nonzero, pick a winner and latch its addr, write, wdata and strb into the APB output registers. Then set psel=1, penable=0 and go to SETUP.
- SETUP: set penable=1, clear the watchdog and go to ACCESS. This state always lasts one cycle.
- ACCESS: hold every APB output stable.
  - pready=1: capture prdata and pslverr, pulse the winner's m_done, clear psel and penable, and go to IDLE.
  - pready=0 with TIMEOUT≠0 and counter = TIMEOUT-1: abort with m_err=1, m_rdata=0 and a done pulse, then go to IDLE.
  - Otherwise: increment the counter.
- pstrb is driven to 0 for reads (APB4 rule). pwdata is also 0 for reads.
- m_rdata and m_err hold their values until the next completion.
- Requests arriving during SETUP or ACCESS wait. They are never dropped.
- If a requester drops m_req before it is granted, the request is withdrawn. Once granted, m_req is not sampled again until done.
- If presetn is asserted mid-transfer, all outputs go to their reset values immediately, the transfer is abandoned and no m_done is issued.

## Timing
- Zero-wait completer: m_req is sampled at edge 0, psel rises after edge 0, penable after edge 1, pready is sampled at edge 2 and m_done pulses after edge 2. The minimum request-to-done latency is 3 cycles.
- Each completer wait state adds one cycle.
- There is always at least one IDLE cycle between transfers. The IDLE cycle that carries m_done also arbitrates the next transfer, so the cycle after a done can already be SETUP.
- Timeout: m_done and m_err appear TIMEOUT cycles after penable rises when pready never asserts.
- m_done is mutually exclusive across requesters and is never asserted two cycles in a row for the same requester.

## Configuration
- Macro APB4_ARB_ROUND_ROBIN_EN.
- Undefined: fixed priority. Requester 0 wins whenever it is eligible, and the last-grant pointer is unused.
- Defined: round-robin. When both requesters are eligible, the one not granted last wins. The pointer updates on every grant. After reset the pointer is 1, so requester 0 wins the first tie.
- A single requester is granted immediately in both modes.

## Test plan
- Single write: m_req=01, addr 0x1234, wdata 0xBEEF, strb 11, zero-wait completer -> SETUP at cycle 1, ACCESS at cycle 2, m_done=01 at cycle 3, m_err=0.
- Read with wait states: requester 1 reads 0x0040 and the completer holds pready low 3 cycles, then returns 0x5A5A -> pstrb=00, m_rdata=0x5A5A, done 6 cycles after request.
- Simultaneous requests, fixed priority (macro off), both held through 3 transfers -> grant order 0,0,0 while requester 0 keeps re-requesting; requester 1 is served once requester 0 drops.
- Same stimulus with APB4_ARB_ROUND_ROBIN_EN -> grant order 0,1,0.
- Timeout: TIMEOUT=16 and pready never asserts -> m_done with m_err=1 and m_rdata=0 exactly 16 cycles after penable; next request proceeds normally.
- pslverr=1 with pready, then presetn pulsed during a later ACCESS -> first done has m_err=1; after the reset pulse all outputs are 0 asynchronously and no done is issued.
